// File: rtl/posit_pkg.sv
// Shared posit types: formats, operations, rounding modes, status flags and the
// request bundle seen by an operation-group unit.
package posit_pkg;

    typedef enum logic [1:0] {
        POSIT32 = 2'd0,
        POSIT16 = 2'd1,
        POSIT8  = 2'd2
    } posit_format_e;

    typedef enum logic [3:0] {
        ADD      = 4'd0,
        SUB      = 4'd1,
        MUL      = 4'd2,
        DIV      = 4'd3,
        SQRT     = 4'd4,
        CMP      = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CLASSIFY = 4'd8
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    localparam int unsigned MAX_WIDTH           = 32;
    localparam int unsigned ISSUE_DEPTH_DEFAULT = 4;

    // Request bundle sized for the widest format; narrower formats use the low bits.
    typedef struct packed {
        logic [1:0][MAX_WIDTH-1:0] operands;
        operation_e                op;
        roundmode_e                rnd_mode;
    } opgroup_req_t;

    function automatic int unsigned posit_width(posit_format_e fmt);
        case (fmt)
            POSIT32: return 32;
            POSIT16: return 16;
            POSIT8:  return 8;
            default: return 32;
        endcase
    endfunction

endpackage

// File: rtl/posit_tag_fifo.sv
// In-order tag FIFO: remembers the tag of every issued operation until the unit
// retires it. Head tag is visible combinationally so it can be re-attached in
// the same cycle the result arrives.
module posit_tag_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 4,
    localparam int unsigned PW       = $clog2(DEPTH),
    localparam int unsigned CW       = PW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [TAG_WIDTH-1:0] data_i,
    output logic [TAG_WIDTH-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CW-1:0]        count_o
);

    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [TAG_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]        count_reg, count_next;
    logic                 push_ok, pop_ok;

    assign full_o  = (count_reg == DEPTH_CNT);
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;
    assign data_o  = mem_reg[rd_ptr_reg];

    // Guard against overflow/underflow; flush overrides both.
    assign push_ok = push_i & ~full_o  & ~flush_i;
    assign pop_ok  = pop_i  & ~empty_o & ~flush_i;

    // Next pointer/count: pointers wrap naturally, simultaneous push+pop keeps count.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and count state; reset discards all in-flight tags immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Tag storage: one write-enabled register per entry, contents need no reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (push_ok && (wr_ptr_reg == PW'(gi))) begin
                mem_reg[gi] <= data_i;
            end
        end
    end

endmodule

// File: rtl/posit_opgroup_issue.sv
// Issue/retire controller for one posit operation-group unit: forwards requests,
// tracks outstanding tags in order, and registers results into a tagged
// response slot. Also drives the unit flush and the aggregate busy flag.
module posit_opgroup_issue
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat  = posit_format_e'(0),
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned DEPTH      = ISSUE_DEPTH_DEFAULT,
    localparam int unsigned WIDTH     = posit_width(pFormat)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0][WIDTH-1:0]   req_operands_i,
    input  operation_e              req_op_i,
    input  roundmode_e              req_rnd_mode_i,
    input  logic [TAG_WIDTH-1:0]    req_tag_i,
    input  logic                    flush_i,
    output logic [1:0][WIDTH-1:0]   unit_operands_o,
    output operation_e              unit_op_o,
    output roundmode_e              unit_rnd_mode_o,
    output logic                    unit_in_valid_o,
    input  logic                    unit_in_ready_i,
    output logic                    unit_flush_o,
    input  logic [WIDTH-1:0]        unit_result_i,
    input  status_t                 unit_status_i,
    input  logic                    unit_out_valid_i,
    output logic                    unit_out_ready_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WIDTH-1:0]        rsp_result_o,
    output status_t                 rsp_status_o,
    output logic [TAG_WIDTH-1:0]    rsp_tag_o,
    output logic                    busy_o,
    output logic                    spurious_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [TAG_WIDTH-1:0] head_tag;
    logic                 issue, retire, pop, slot_free;

    logic                 rsp_valid_reg;
    logic [WIDTH-1:0]     rsp_result_reg;
    status_t              rsp_status_reg;
    logic [TAG_WIDTH-1:0] rsp_tag_reg;
    logic                 spurious_reg;

    // Request path to the unit is pure wiring; only the handshake is gated.
    assign unit_operands_o = req_operands_i;
    assign unit_op_o       = req_op_i;
    assign unit_rnd_mode_o = req_rnd_mode_i;
    assign unit_flush_o    = flush_i;

    // A full FIFO blocks issue even if a retire frees an entry this same cycle,
    // keeping the ready path off the output handshake.
    assign unit_in_valid_o = req_valid_i & ~fifo_full & ~flush_i;
    assign req_ready_o     = unit_in_ready_i & ~fifo_full & ~flush_i;
    assign issue           = req_valid_i & req_ready_o;

    assign slot_free        = ~rsp_valid_reg | rsp_ready_i;
    assign unit_out_ready_o = slot_free & ~flush_i;
    assign retire           = unit_out_valid_i & unit_out_ready_o;
    assign pop              = retire & ~fifo_empty;

    posit_tag_fifo #(
        .DEPTH     (DEPTH),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (issue),
        .pop_i   (pop),
        .data_i  (req_tag_i),
        .data_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Response slot: load on retire with the head tag, empty on consume or flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_status_reg <= '0;
            rsp_tag_reg    <= '0;
        end else if (flush_i) begin
            rsp_valid_reg  <= 1'b0;
        end else if (pop) begin
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= unit_result_i;
            rsp_status_reg <= unit_status_i;
            rsp_tag_reg    <= head_tag;
        end else if (rsp_ready_i) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

    // Sticky flag for a result with no matching outstanding tag; survives flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spurious_reg <= 1'b0;
        end else if (retire && fifo_empty) begin
            spurious_reg <= 1'b1;
        end
    end

    assign rsp_valid_o  = rsp_valid_reg;
    assign rsp_result_o = rsp_result_reg;
    assign rsp_status_o = rsp_status_reg;
    assign rsp_tag_o    = rsp_tag_reg;
    assign spurious_o   = spurious_reg;
    assign busy_o       = (fifo_count != '0) | rsp_valid_reg;

endmodule

// File: tb/tb_posit_opgroup_issue.sv
// Bench for posit_opgroup_issue: directed scenarios plus a randomized run, all
// checked against a queue-based model of outstanding tags and the response slot.
module tb_posit_opgroup_issue;
    import posit_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int W     = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                req_valid, req_ready, flush;
    logic [1:0][W-1:0]   req_operands, unit_operands;
    operation_e          req_op, unit_op;
    roundmode_e          req_rnd, unit_rnd;
    logic [TW-1:0]       req_tag, rsp_tag;
    logic                unit_in_valid, unit_in_ready, unit_flush;
    logic [W-1:0]        unit_result, rsp_result;
    status_t             unit_status, rsp_status;
    logic                unit_out_valid, unit_out_ready;
    logic                rsp_valid, rsp_ready, busy, spurious;

    posit_opgroup_issue #(
        .pFormat   (POSIT32),
        .TAG_WIDTH (TW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_operands_i   (req_operands),
        .req_op_i         (req_op),
        .req_rnd_mode_i   (req_rnd),
        .req_tag_i        (req_tag),
        .flush_i          (flush),
        .unit_operands_o  (unit_operands),
        .unit_op_o        (unit_op),
        .unit_rnd_mode_o  (unit_rnd),
        .unit_in_valid_o  (unit_in_valid),
        .unit_in_ready_i  (unit_in_ready),
        .unit_flush_o     (unit_flush),
        .unit_result_i    (unit_result),
        .unit_status_i    (unit_status),
        .unit_out_valid_i (unit_out_valid),
        .unit_out_ready_o (unit_out_ready),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_result_o     (rsp_result),
        .rsp_status_o     (rsp_status),
        .rsp_tag_o        (rsp_tag),
        .busy_o           (busy),
        .spurious_o       (spurious)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding tags in issue order plus the response slot.
    logic [TW-1:0] m_tags[$];
    logic          m_valid;
    logic [W-1:0]  m_res;
    status_t       m_stat;
    logic [TW-1:0] m_tag;
    logic          m_spur;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_tags.delete();
        m_valid = 1'b0;
        m_spur  = 1'b0;
    endfunction

    // One clock cycle: drive inputs, check combinational handshake, advance the
    // model with the spec rules, then check the registered outputs.
    task automatic step(input bit rv, input logic [TW-1:0] tag, input bit fl,
                        input bit inr, input bit ov, input bit rr, input logic [W-1:0] res);
        bit full, e_req_ready, e_in_valid, e_out_ready, retire, issue;
        @(negedge clk);
        req_valid      = rv;
        req_tag        = tag;
        flush          = fl;
        unit_in_ready  = inr;
        unit_out_valid = ov;
        rsp_ready      = rr;
        unit_result    = res;
        req_operands   = {$urandom, $urandom};
        req_op         = operation_e'(4'($urandom_range(0, 8)));
        req_rnd        = roundmode_e'(3'($urandom_range(0, 4)));
        unit_status    = status_t'(5'($urandom_range(0, 31)));
        #1;
        full        = (m_tags.size() == DEPTH);
        e_req_ready = inr && !full && !fl;
        e_in_valid  = rv && !full && !fl;
        e_out_ready = (!m_valid || rr) && !fl;
        check_eq("req_ready", req_ready, e_req_ready);
        check_eq("unit_in_valid", unit_in_valid, e_in_valid);
        check_eq("unit_out_ready", unit_out_ready, e_out_ready);
        check_eq("unit_flush", unit_flush, fl);
        check_eq("forward", {unit_operands, unit_op, unit_rnd}, {req_operands, req_op, req_rnd});

        if (fl) begin
            m_tags.delete();
            m_valid = 1'b0;
        end else begin
            retire = ov && e_out_ready;
            issue  = rv && e_req_ready;
            if (retire && m_tags.size() > 0) begin
                m_valid = 1'b1;
                m_res   = res;
                m_stat  = unit_status;
                m_tag   = m_tags.pop_front();
            end else begin
                if (retire) m_spur = 1'b1;
                if (rr)     m_valid = 1'b0;
            end
            if (issue) m_tags.push_back(tag);
        end

        @(posedge clk);
        #1;
        check_eq("rsp_valid", rsp_valid, m_valid);
        check_eq("busy", busy, (m_tags.size() != 0) || m_valid);
        check_eq("spurious", spurious, m_spur);
        if (m_valid) begin
            check_eq("rsp_result", rsp_result, m_res);
            check_eq("rsp_status", rsp_status, m_stat);
            check_eq("rsp_tag", rsp_tag, m_tag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_tag = '0; flush = 0; unit_in_ready = 0;
        unit_out_valid = 0; rsp_ready = 0; unit_result = '0; unit_status = '0;
        req_operands = '0; req_op = ADD; req_rnd = RNE;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_result", rsp_result, '0);
        check_eq("rst_rsp_status", rsp_status, '0);
        check_eq("rst_rsp_tag", rsp_tag, '0);
        check_eq("rst_spurious", spurious, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single operation: tag 3, result 1 two cycles later, then consumed.
        step(1, 4'd3, 0, 1, 0, 0, '0);
        step(0, 4'd0, 0, 1, 0, 0, '0);
        step(0, 4'd0, 0, 1, 1, 0, 32'd1);
        step(0, 4'd0, 0, 1, 0, 1, '0);

        // Fill to depth with the unit stalled, attempt a fifth, then drain in order.
        for (int i = 0; i < 5; i++) step(1, TW'(i), 0, 1, 0, 1, '0);
        for (int i = 0; i < 5; i++) step(0, 4'd0, 0, 1, (i < 4), 1, $urandom);

        // Backpressure: slot held while consumer stalls, then releases into next result.
        step(1, 4'd7, 0, 1, 0, 1, '0);
        step(1, 4'd8, 0, 1, 1, 0, $urandom);
        step(0, 4'd0, 0, 1, 1, 0, $urandom);
        step(0, 4'd0, 0, 1, 1, 1, $urandom);
        step(0, 4'd0, 0, 1, 0, 1, '0);

        // Flush with three outstanding and a valid slot; request in flush cycle refused.
        for (int i = 0; i < 4; i++) step(1, TW'(9 + i), 0, 1, (i == 3), 0, $urandom);
        step(1, 4'd13, 1, 1, 1, 0, $urandom);
        step(0, 4'd0, 0, 1, 0, 0, '0);

        // Spurious result with nothing outstanding.
        step(0, 4'd0, 0, 1, 1, 1, $urandom);
        step(0, 4'd0, 0, 1, 0, 1, '0);

        // Randomized traffic with varying pressure on each side.
        for (int i = 0; i < 1500; i++) begin
            int ph;
            bit ov;
            ph = i / 250;
            ov = (m_tags.size() > 0) && ($urandom_range(0, 5) < ph);
            step($urandom_range(0, 9) < 7, TW'($urandom), $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 8, ov, $urandom_range(0, 5) >= (ph % 3), $urandom);
        end

        // Asynchronous reset between edges with work in flight.
        step(1, 4'd5, 0, 1, 0, 1, '0);
        @(negedge clk);
        req_valid = 0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rsp_valid", rsp_valid, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_spurious", spurious, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 4'd0, 0, 1, 0, 1, '0);
        step(1, 4'd6, 0, 1, 0, 1, '0);
        step(0, 4'd0, 0, 1, 1, 1, $urandom);
        step(0, 4'd0, 0, 1, 0, 1, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
